// File: rtl/wave_meter.sv
// wave_meter: frequency and peak-amplitude meter for a signed 12-bit sample stream.
// freq = F_S_HZ*NPER / (samples spanning NPER rising crossings), computed by a serial divider.
module wave_meter #(
  parameter int F_S_HZ  = 20000,
  parameter int NPER    = 4,
  parameter int HYST    = 16,
  parameter int TIMEOUT = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_s,
  input  logic signed [11:0] din,
  output logic        [18:0] freq,
  output logic        [11:0] amp,
  output logic               valid,
  output logic               ovr
);
  typedef enum logic {HUNT, MEAS} state_t;

  localparam logic signed [11:0] HYST_P   = 12'(HYST);
  localparam logic signed [11:0] HYST_N   = 12'(-HYST);
  localparam logic        [31:0] DIVIDEND = 32'(F_S_HZ * NPER);
  localparam logic        [19:0] CNT_MAX  = 20'hFFFFF;
  localparam logic        [19:0] TO_LIM   = 20'(TIMEOUT);
  localparam logic        [4:0]  NPER_L   = 5'(NPER);

  function automatic logic [11:0] half_span(input logic signed [11:0] hi,
                                            input logic signed [11:0] lo);
    logic signed [12:0] d;
    d = {hi[11], hi} - {lo[11], lo};
    return d[12:1];
  endfunction

  function automatic logic [18:0] sat_freq(input logic [31:0] q);
    return (|q[31:19]) ? 19'h7FFFF : q[18:0];
  endfunction

  state_t             state_q, state_d;
  logic               f_s_q, f_s_d, below_q, below_d, busy_q, busy_d;
  logic               valid_q, valid_d, ovr_q, ovr_d;
  logic        [19:0] cnt_q, cnt_d, idle_q, idle_d, dvs_q, dvs_d, rem_q, rem_d;
  logic        [4:0]  ncross_q, ncross_d, it_q, it_d;
  logic signed [11:0] min_q, min_d, max_q, max_d;
  logic        [31:0] quo_q, quo_d, quo_nxt;
  logic        [11:0] amp_pend_q, amp_pend_d, amp_q, amp_d;
  logic        [18:0] freq_q, freq_d;
  logic        [19:0] cnt_inc, idle_inc;
  logic        [20:0] trial;
  logic               strb, xr, to_hit, close, ge;

  always_comb begin
    strb     = f_s & ~f_s_q;
    xr       = strb & below_q & (din >= HYST_P);
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;
    idle_inc = idle_q + 20'd1;
    to_hit   = strb & ~xr & (idle_inc >= TO_LIM);
    close    = (state_q == MEAS) & xr & ((ncross_q + 5'd1) == NPER_L);
    trial    = {rem_q, quo_q[31]};
    ge       = trial >= {1'b0, dvs_q};
    quo_nxt  = {quo_q[30:0], ge};

    f_s_d      = f_s;
    below_d    = below_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    ncross_d   = ncross_q;
    idle_d     = idle_q;
    min_d      = min_q;
    max_d      = max_q;
    busy_d     = busy_q;
    it_d       = it_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    amp_pend_d = amp_pend_q;
    freq_d     = freq_q;
    amp_d      = amp_q;
    valid_d    = 1'b0;
    ovr_d      = ovr_q;

    if (strb) begin
      if (xr)                 below_d = 1'b0;
      else if (din <= HYST_N) below_d = 1'b1;
      min_d  = (din < min_q) ? din : min_q;
      max_d  = (din > max_q) ? din : max_q;
      idle_d = xr ? 20'd0 : idle_inc;
    end

    case (state_q)
      HUNT: if (xr) begin
        state_d  = MEAS;
        cnt_d    = '0;
        ncross_d = '0;
        min_d    = din;
        max_d    = din;
      end
      MEAS: if (strb) begin
        cnt_d = cnt_inc;
        // The closing strobe doubles as the first sample of the next window.
        if (close) begin
          cnt_d    = '0;
          ncross_d = '0;
          min_d    = din;
          max_d    = din;
        end else if (xr) begin
          ncross_d = ncross_q + 5'd1;
        end
      end
      default: state_d = HUNT;
    endcase

    if (to_hit) begin
      freq_d   = '0;
      amp_d    = half_span(max_q, min_q);
      valid_d  = 1'b1;
      state_d  = HUNT;
      cnt_d    = '0;
      ncross_d = '0;
      idle_d   = '0;
      min_d    = din;
      max_d    = din;
    end

    if (close && busy_q) ovr_d = 1'b1;
    if (close && !busy_q) begin
      busy_d     = 1'b1;
      it_d       = '0;
      rem_d      = '0;
      quo_d      = DIVIDEND;
      dvs_d      = cnt_inc;
      amp_pend_d = half_span(max_q, min_q);
    end

    // Restoring divide step; the final step overrides any same-cycle timeout report.
    if (busy_q) begin
      rem_d = ge ? 20'(trial - {1'b0, dvs_q}) : trial[19:0];
      quo_d = quo_nxt;
      it_d  = it_q + 5'd1;
      if (it_q == 5'd31) begin
        busy_d  = 1'b0;
        freq_d  = sat_freq(quo_nxt);
        amp_d   = amp_pend_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_s_q    <= 1'b0;
      below_q  <= 1'b0;
      state_q  <= HUNT;
      cnt_q    <= '0;
      ncross_q <= '0;
      idle_q   <= '0;
      min_q    <= '0;
      max_q    <= '0;
      busy_q   <= 1'b0;
      it_q     <= '0;
      freq_q   <= '0;
      amp_q    <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      f_s_q    <= f_s_d;
      below_q  <= below_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ncross_q <= ncross_d;
      idle_q   <= idle_d;
      min_q    <= min_d;
      max_q    <= max_d;
      busy_q   <= busy_d;
      it_q     <= it_d;
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  // Divider datapath: only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    rem_q      <= rem_d;
    quo_q      <= quo_d;
    dvs_q      <= dvs_d;
    amp_pend_q <= amp_pend_d;
  end

  assign freq  = freq_q;
  assign amp   = amp_q;
  assign valid = valid_q;
  assign ovr   = ovr_q;
endmodule

// File: tb/tb_wave_meter.sv
// Scoreboard bench for wave_meter: directed square waves, timeout, overrun and reset cases.
module tb_wave_meter;
  localparam int TO = 1000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               f_s = 1'b0;
  logic signed [11:0] din = '0;
  logic        [18:0] freq;
  logic        [11:0] amp;
  logic               valid, ovr;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  typedef struct {
    int f;
    int a;
    int c;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;

  wave_meter #(.F_S_HZ(20000), .NPER(4), .HYST(16), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .f_s  (f_s),
    .din  (din),
    .freq (freq),
    .amp  (amp),
    .valid(valid),
    .ovr  (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every valid pulse must match the oldest expected result, at its exact cycle.
  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", int'(valid), 0);
      end else begin
        e_mon = q.pop_front();
        chk("freq", int'(freq), e_mon.f);
        chk("amp", int'(amp), e_mon.a);
        chk("valid_cycle", cyc, e_mon.c);
      end
    end
  end

  // One sample = one strobe, every 2 clk; optionally queue the result expected lat clk later.
  task automatic sample(input int v, input bit push, input int lat, input int ef, input int ea);
    exp_t e;
    @(posedge clk); #1;
    f_s = 1'b1;
    din = 12'(v);
    if (push) begin
      e.f = ef;
      e.a = ea;
      e.c = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    f_s = 1'b0;
  endtask

  task automatic burst();
    for (int i = 0; i < 5; i++) sample((i % 2 == 0) ? 10 : -10, 1'b0, 0, 0, 0);
  endtask

  task automatic period(input int half, input int a, input bit noise, input bit close,
                        input int ef, input int ea);
    int n;
    n = noise ? half - 5 : half;
    for (int i = 0; i < n; i++) sample(-a, 1'b0, 0, 0, 0);
    if (noise) burst();
    for (int i = 0; i < n; i++) sample(a, close && (i == 0), 33, ef, ea);
    if (noise) burst();
  endtask

  // Period 1's rising edge opens a window; periods 5, 9, 13... close one.
  task automatic wave(input int half, input int a, input bit noise, input int p0, input int p1,
                      input int ef, input int ea);
    for (int p = p0; p <= p1; p++)
      period(half, a, noise, (p > 1) && ((p - 1) % 4 == 0), ef, ea);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_freq"}, int'(freq), 0);
    chk({tag, "_amp"}, int'(amp), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_ovr"}, int'(ovr), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");

    // 200 Hz +-800: cnt 400 -> freq 200, then a +300 crossing held until timeout.
    wave(50, 800, 1'b0, 1, 8, 200, 800);
    for (int i = 0; i < 50; i++) sample(-800, 1'b0, 0, 0, 0);
    sample(300, 1'b1, 33, 200, 800);
    for (int i = 1; i <= TO; i++) sample(300, i == TO, 1, 0, 0);
    wave(50, 800, 1'b0, 1, 5, 200, 800);
    drain();

    // 1000 Hz +-500: results every 80 strobes.
    do_reset();
    wave(10, 500, 1'b0, 1, 13, 1000, 500);
    drain();

    // Hysteresis: +-10 bursts around zero must not add crossings.
    do_reset();
    wave(50, 800, 1'b1, 1, 9, 200, 800);
    drain();

    // Overrun: 2 samples/period, windows every 8 strobes while the divide takes 33 clk.
    do_reset();
    wave(1, 400, 1'b0, 1, 8, 10000, 400);
    @(negedge clk);
    chk("ovr_before_overrun", int'(ovr), 0);
    for (int p = 9; p <= 17; p++) period(1, 400, 1'b0, 1'b0, 0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ovr_sticky", int'(ovr), 1);
    chk("freq_hold", int'(freq), 10000);
    chk("amp_hold", int'(amp), 400);

    // Reset mid-divide: outputs clear, the aborted result never appears.
    do_reset();
    chk_zero("reset_mid_div");
    wave(50, 800, 1'b0, 1, 5, 200, 800);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
